ex_stage_fwd_md: RTL and testbench

- Parametrised next-generation execute stage of the DLX pipeline.
- Single-cycle integer ALU plus an iterative multiply/divide unit (MDU) that stalls upstream stages.
- Two-level operand forwarding (MEM, then WB); register 0 is never forwarded.
- Load-use hazard detection with bubble insertion, and branch resolution with flush.
- Feeds the EX/MEM pipeline register.

---
 rtl/ex_stage_fwd_md.sv | 204 ++++++++++++++++++++
 tb/tb_ex_stage_fwd_md.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage_fwd_md.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ex_stage_fwd_md                                                          |
// | DLX execute stage: forwarding ALU, iterative MUL/DIVU/REMU, hazards.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module ex_stage_fwd_md #(
   parameter int XLEN  = 32,
   parameter int RA_W  = 5,
   parameter int MD_EN = 1
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            valid_EX,
   input  logic            Pc_cmd_ex_EX,
   input  logic            d_write_enable_EX,
   input  logic            d_load_enable_EX,
   input  logic            Iv_alu_EX,
   input  logic            Pc_alu_EX,
   input  logic [3:0]      op_EX,
   input  logic [RA_W-1:0] Rd_EX,
   input  logic [RA_W-1:0] Rs1_EX,
   input  logic [RA_W-1:0] Rs2_EX,
   input  logic [XLEN-1:0] Iv_EX,
   input  logic [XLEN-1:0] S1_EX,
   input  logic [XLEN-1:0] S2_EX,
   input  logic [XLEN-1:0] PC_EX,
   input  logic [XLEN-1:0] ALU_out_MEM_backward,
   input  logic [RA_W-1:0] Rd_MEM_backward,
   input  logic [XLEN-1:0] WB_data_backward,
   input  logic [RA_W-1:0] Rd_WB_backward,
   output logic            stall_EX,
   output logic            flush_EX,
   output logic            pc_cmd_EX,
   output logic [XLEN-1:0] pc_in_EX,
   output logic [XLEN-1:0] ALU_out_MEM,
   output logic            d_write_enable_MEM,
   output logic            d_load_enable_MEM,
   output logic [RA_W-1:0] Rd_MEM,
   output logic [XLEN-1:0] S2_MEM
);

   localparam int SH_W  = $clog2(XLEN);
   localparam int CNT_W = $clog2(XLEN);

   typedef enum logic [1:0] {
      MD_IDLE = 2'd0,
      MD_BUSY = 2'd1,
      MD_DONE = 2'd2
   } md_state_t;

   logic [XLEN-1:0] w_rs1_val, w_rs2_val, w_op1, w_op2;
   logic [XLEN-1:0] w_alu_res, w_md_res, w_ex_res;
   logic            w_zf, w_hazard, w_is_md, w_md_stall, w_branch;

   // A load still in MEM has no data yet, so it must not be forwarded from there
   always_comb begin
      w_rs1_val = S1_EX;
      if (Rs1_EX != '0 && Rs1_EX == Rd_MEM_backward && !d_load_enable_MEM)
         w_rs1_val = ALU_out_MEM_backward;
      else if (Rs1_EX != '0 && Rs1_EX == Rd_WB_backward)
         w_rs1_val = WB_data_backward;

      w_rs2_val = S2_EX;
      if (Rs2_EX != '0 && Rs2_EX == Rd_MEM_backward && !d_load_enable_MEM)
         w_rs2_val = ALU_out_MEM_backward;
      else if (Rs2_EX != '0 && Rs2_EX == Rd_WB_backward)
         w_rs2_val = WB_data_backward;
   end

   assign w_op1 = Pc_alu_EX ? PC_EX : w_rs1_val;
   assign w_op2 = Iv_alu_EX ? Iv_EX : w_rs2_val;

   always_comb begin
      w_alu_res = '0;
      case (op_EX)
         4'd0:    w_alu_res = w_op1 + w_op2;
         4'd1:    w_alu_res = w_op1 - w_op2;
         4'd2:    w_alu_res = w_op1 & w_op2;
         4'd3:    w_alu_res = w_op1 | w_op2;
         4'd4:    w_alu_res = w_op1 ^ w_op2;
         4'd5:    w_alu_res = w_op1 << w_op2[SH_W-1:0];
         4'd6:    w_alu_res = w_op1 >> w_op2[SH_W-1:0];
         4'd7:    w_alu_res = {{(XLEN-1){1'b0}}, $signed(w_op1) < $signed(w_op2)};
         4'd8:    w_alu_res = {{(XLEN-1){1'b0}}, w_op1 == w_op2};
         default: w_alu_res = '0;
      endcase
   end

   assign w_zf     = (w_alu_res == '0);
   assign w_is_md  = valid_EX && (op_EX == 4'd9 || op_EX == 4'd10 || op_EX == 4'd11);
   assign w_hazard = valid_EX && d_load_enable_MEM && (Rd_MEM != '0) &&
                     (Rs1_EX == Rd_MEM || Rs2_EX == Rd_MEM);

   assign stall_EX  = w_hazard | w_md_stall;
   assign w_branch  = valid_EX & Pc_cmd_ex_EX & w_zf & ~stall_EX;
   assign pc_cmd_EX = w_branch;
   assign flush_EX  = w_branch;
   assign pc_in_EX  = PC_EX + Iv_EX;

   generate
      if (MD_EN != 0) begin : g_mdu
         md_state_t        r_state, w_state_nxt;
         logic [CNT_W-1:0] r_cnt;
         logic [XLEN-1:0]  r_acc, r_a, r_b;
         logic [1:0]       r_op;
         logic             w_div_zero;
         logic [XLEN:0]    w_rem_sh, w_rem_sub;

         // MUL: acc=product, a=multiplicand, b=multiplier. DIV: acc=remainder, a=divisor, b=quotient
         assign w_div_zero = (op_EX != 4'd9) && (w_op2 == '0);
         assign w_rem_sh   = {r_acc, r_b[XLEN-1]};
         assign w_rem_sub  = w_rem_sh - {1'b0, r_a};
         assign w_md_res   = (r_op == 2'b10) ? r_b : r_acc;

         always_comb begin
            w_state_nxt = r_state;
            w_md_stall  = 1'b0;
            case (r_state)
               MD_IDLE: begin
                  if (w_is_md && !w_hazard) begin
                     w_md_stall  = 1'b1;
                     w_state_nxt = w_div_zero ? MD_DONE : MD_BUSY;
                  end
               end
               MD_BUSY: begin
                  w_md_stall = 1'b1;
                  if (r_cnt == CNT_W'(XLEN-1))
                     w_state_nxt = MD_DONE;
               end
               MD_DONE: w_state_nxt = MD_IDLE;
               default: w_state_nxt = MD_IDLE;
            endcase
         end

         always_ff @(posedge clk) begin
            if (!reset_n) begin
               r_state <= MD_IDLE;
               r_cnt   <= '0;
               r_acc   <= '0;
               r_a     <= '0;
               r_b     <= '0;
               r_op    <= '0;
            end else begin
               r_state <= w_state_nxt;
               if (r_state == MD_IDLE && w_state_nxt != MD_IDLE) begin
                  r_cnt <= '0;
                  r_op  <= op_EX[1:0];
                  if (w_div_zero) begin
                     r_acc <= w_op1;
                     r_a   <= '0;
                     r_b   <= '1;
                  end else if (op_EX == 4'd9) begin
                     r_acc <= '0;
                     r_a   <= w_op1;
                     r_b   <= w_op2;
                  end else begin
                     r_acc <= '0;
                     r_a   <= w_op2;
                     r_b   <= w_op1;
                  end
               end else if (r_state == MD_BUSY) begin
                  r_cnt <= r_cnt + 1'b1;
                  if (r_op == 2'b01) begin
                     if (r_b[0])
                        r_acc <= r_acc + r_a;
                     r_a <= r_a << 1;
                     r_b <= r_b >> 1;
                  end else if (!w_rem_sub[XLEN]) begin
                     r_acc <= w_rem_sub[XLEN-1:0];
                     r_b   <= {r_b[XLEN-2:0], 1'b1};
                  end else begin
                     r_acc <= w_rem_sh[XLEN-1:0];
                     r_b   <= {r_b[XLEN-2:0], 1'b0};
                  end
               end
            end
         end
      end else begin : g_no_mdu
         assign w_md_stall = 1'b0;
         assign w_md_res   = '0;
      end
   endgenerate

   assign w_ex_res = w_is_md ? w_md_res : w_alu_res;

   always_ff @(posedge clk) begin
      if (!reset_n || !valid_EX || stall_EX) begin
         ALU_out_MEM        <= '0;
         d_write_enable_MEM <= 1'b0;
         d_load_enable_MEM  <= 1'b0;
         Rd_MEM             <= '0;
         S2_MEM             <= '0;
      end else begin
         ALU_out_MEM        <= w_ex_res;
         d_write_enable_MEM <= d_write_enable_EX;
         d_load_enable_MEM  <= d_load_enable_EX;
         Rd_MEM             <= Rd_EX;
         S2_MEM             <= w_rs2_val;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ex_stage_fwd_md.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_ex_stage_fwd_md                                                       |
// | Scoreboard bench for ex_stage_fwd_md against a behavioural model.        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_ex_stage_fwd_md;

   localparam int XLEN  = 32;
   localparam int RA_W  = 5;
   localparam int MD_EN = 1;

   logic            clk = 1'b0;
   logic            reset_n;
   logic            valid_EX, Pc_cmd_ex_EX, d_write_enable_EX, d_load_enable_EX;
   logic            Iv_alu_EX, Pc_alu_EX;
   logic [3:0]      op_EX;
   logic [RA_W-1:0] Rd_EX, Rs1_EX, Rs2_EX, Rd_MEM_backward, Rd_WB_backward;
   logic [XLEN-1:0] Iv_EX, S1_EX, S2_EX, PC_EX, ALU_out_MEM_backward, WB_data_backward;
   logic            stall_EX, flush_EX, pc_cmd_EX;
   logic [XLEN-1:0] pc_in_EX, ALU_out_MEM, S2_MEM;
   logic            d_write_enable_MEM, d_load_enable_MEM;
   logic [RA_W-1:0] Rd_MEM;

   ex_stage_fwd_md #(.XLEN(XLEN), .RA_W(RA_W), .MD_EN(MD_EN)) dut (
      .clk(clk), .reset_n(reset_n), .valid_EX(valid_EX), .Pc_cmd_ex_EX(Pc_cmd_ex_EX),
      .d_write_enable_EX(d_write_enable_EX), .d_load_enable_EX(d_load_enable_EX),
      .Iv_alu_EX(Iv_alu_EX), .Pc_alu_EX(Pc_alu_EX), .op_EX(op_EX),
      .Rd_EX(Rd_EX), .Rs1_EX(Rs1_EX), .Rs2_EX(Rs2_EX),
      .Iv_EX(Iv_EX), .S1_EX(S1_EX), .S2_EX(S2_EX), .PC_EX(PC_EX),
      .ALU_out_MEM_backward(ALU_out_MEM_backward), .Rd_MEM_backward(Rd_MEM_backward),
      .WB_data_backward(WB_data_backward), .Rd_WB_backward(Rd_WB_backward),
      .stall_EX(stall_EX), .flush_EX(flush_EX), .pc_cmd_EX(pc_cmd_EX), .pc_in_EX(pc_in_EX),
      .ALU_out_MEM(ALU_out_MEM), .d_write_enable_MEM(d_write_enable_MEM),
      .d_load_enable_MEM(d_load_enable_MEM), .Rd_MEM(Rd_MEM), .S2_MEM(S2_MEM)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic            valid, br, we, le, iv, pca;
      logic [3:0]      op;
      logic [RA_W-1:0] rd, rs1, rs2, mem_rd, wb_rd;
      logic [XLEN-1:0] iv_v, s1, s2, pc, mem_out, wb_data;
   } instr_t;

   typedef struct {
      logic [XLEN-1:0] res, s2, pc_in;
      logic [RA_W-1:0] rd;
      logic            we, le, pc_cmd, bubble;
      int              stalls;
   } exp_t;

   exp_t            q[$];
   int              checks   = 0;
   int              failures = 0;
   logic            sb_en    = 1'b0;
   logic            m_load   = 1'b0;
   logic [RA_W-1:0] m_rd     = '0;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
      end
   endtask

   function automatic instr_t nop();
      instr_t t;
      t.valid = 0; t.br = 0; t.we = 0; t.le = 0; t.iv = 0; t.pca = 0; t.op = '0;
      t.rd = '0; t.rs1 = '0; t.rs2 = '0; t.mem_rd = '0; t.wb_rd = '0;
      t.iv_v = '0; t.s1 = '0; t.s2 = '0; t.pc = '0; t.mem_out = '0; t.wb_data = '0;
      return t;
   endfunction

   // Architectural operation results, straight from the op table
   function automatic logic [XLEN-1:0] calc(input logic [3:0] op, input logic [XLEN-1:0] a,
                                            input logic [XLEN-1:0] b);
      int unsigned sh;
      sh = b % XLEN;
      case (op)
         4'd0:  return a + b;
         4'd1:  return a - b;
         4'd2:  return a & b;
         4'd3:  return a | b;
         4'd4:  return a ^ b;
         4'd5:  return a << sh;
         4'd6:  return a >> sh;
         4'd7:  return ($signed(a) < $signed(b)) ? XLEN'(1) : '0;
         4'd8:  return (a == b) ? XLEN'(1) : '0;
         4'd9:  return a * b;
         4'd10: return (b == '0) ? '1 : a / b;
         4'd11: return (b == '0) ? a : a % b;
         default: return '0;
      endcase
   endfunction

   function automatic logic [XLEN-1:0] fwd(input logic [RA_W-1:0] rs, input logic [XLEN-1:0] rf,
                                           input instr_t t, input logic mem_load);
      if (rs != '0 && rs == t.mem_rd && !mem_load) return t.mem_out;
      if (rs != '0 && rs == t.wb_rd) return t.wb_data;
      return rf;
   endfunction

   task automatic predict(input instr_t t, output exp_t e);
      logic            hazard, is_md, load_start, load_fin;
      logic [XLEN-1:0] a0, b0, af, bf, single;
      hazard = t.valid && m_load && m_rd != '0 && (t.rs1 == m_rd || t.rs2 == m_rd);
      is_md  = t.valid && (t.op >= 4'd9 && t.op <= 4'd11);
      e.stalls   = hazard ? 1 : 0;
      load_start = hazard ? 1'b0 : m_load;
      a0 = t.pca ? t.pc : fwd(t.rs1, t.s1, t, load_start);
      b0 = t.iv ? t.iv_v : fwd(t.rs2, t.s2, t, load_start);
      if (is_md) e.stalls += (t.op != 4'd9 && b0 == '0) ? 1 : XLEN + 1;
      // after any stall the EX/MEM slot holds a bubble, never a load
      load_fin = (e.stalls > 0) ? 1'b0 : m_load;
      af = t.pca ? t.pc : fwd(t.rs1, t.s1, t, load_fin);
      bf = t.iv ? t.iv_v : fwd(t.rs2, t.s2, t, load_fin);
      single   = (t.op >= 4'd9) ? '0 : calc(t.op, af, bf);
      e.bubble = !t.valid;
      e.res    = !t.valid ? '0 : (is_md ? calc(t.op, a0, b0) : single);
      e.rd     = t.valid ? t.rd : '0;
      e.we     = t.valid & t.we;
      e.le     = t.valid & t.le;
      e.s2     = fwd(t.rs2, t.s2, t, load_fin);
      e.pc_cmd = t.valid & t.br & (single == '0);
      e.pc_in  = t.pc + t.iv_v;
      m_load   = t.valid & t.le;
      m_rd     = t.valid ? t.rd : '0;
   endtask

   task automatic drive(input instr_t t);
      valid_EX = t.valid; Pc_cmd_ex_EX = t.br; d_write_enable_EX = t.we; d_load_enable_EX = t.le;
      Iv_alu_EX = t.iv; Pc_alu_EX = t.pca; op_EX = t.op;
      Rd_EX = t.rd; Rs1_EX = t.rs1; Rs2_EX = t.rs2;
      Iv_EX = t.iv_v; S1_EX = t.s1; S2_EX = t.s2; PC_EX = t.pc;
      ALU_out_MEM_backward = t.mem_out; Rd_MEM_backward = t.mem_rd;
      WB_data_backward = t.wb_data; Rd_WB_backward = t.wb_rd;
   endtask

   // Called at posedge+2; returns at posedge+2 after the instruction leaves EX
   task automatic issue(input instr_t t);
      exp_t e;
      int   n;
      predict(t, e);
      q.push_back(e);
      drive(t);
      n = 0;
      @(negedge clk);
      while (stall_EX === 1'b1 && n < 200) begin
         n++;
         @(negedge clk);
      end
      if (n >= 200) chk("accept_timeout", 64'(n), 64'(e.stalls));
      @(posedge clk);
      #2;
   endtask

   function automatic logic [XLEN-1:0] rnd_val();
      case ($urandom_range(0, 3))
         0:       return '0;
         1:       return XLEN'($urandom_range(0, 40));
         default: return XLEN'($urandom);
      endcase
   endfunction

   function automatic instr_t rand_instr();
      instr_t t;
      int     r;
      t = nop();
      t.valid = ($urandom_range(0, 9) != 0);
      r = $urandom_range(0, 19);
      if (r < 14)      t.op = 4'(r % 9);
      else if (r < 17) t.op = 4'(9 + r - 14);
      else             t.op = 4'(12 + $urandom_range(0, 3));
      t.br  = (t.op < 4'd9) && ($urandom_range(0, 3) == 0);
      t.le  = !t.br && ($urandom_range(0, 3) == 0);
      t.we  = !t.br && !t.le && ($urandom_range(0, 5) == 0);
      t.iv  = ($urandom_range(0, 2) == 0);
      t.pca = ($urandom_range(0, 7) == 0);
      t.rd = RA_W'($urandom_range(0, 3)); t.rs1 = RA_W'($urandom_range(0, 3));
      t.rs2 = RA_W'($urandom_range(0, 3)); t.mem_rd = RA_W'($urandom_range(0, 3));
      t.wb_rd = RA_W'($urandom_range(0, 3));
      t.iv_v = rnd_val(); t.s1 = rnd_val(); t.s2 = rnd_val(); t.pc = rnd_val();
      t.mem_out = rnd_val(); t.wb_data = rnd_val();
      return t;
   endfunction

   // Monitor: counts stall cycles, then checks EX/MEM once the instruction is accepted
   initial begin
      int   st;
      logic pcc, fl;
      logic [XLEN-1:0] pin;
      exp_t e;
      st = 0;
      forever begin
         @(negedge clk);
         if (!sb_en) begin
            st = 0;
         end else if (stall_EX === 1'b1) begin
            st++;
            chk("pc_cmd_while_stalled", {63'd0, pc_cmd_EX}, 64'd0);
         end else begin
            pcc = pc_cmd_EX; fl = flush_EX; pin = pc_in_EX;
            @(posedge clk);
            #1;
            if (q.size() == 0) begin
               chk("scoreboard_underflow", 64'(q.size()), 64'd1);
            end else begin
               e = q.pop_front();
               chk("stall_cycles", 64'(st), 64'(e.stalls));
               chk("ALU_out_MEM", 64'(ALU_out_MEM), 64'(e.res));
               chk("Rd_MEM", 64'(Rd_MEM), 64'(e.rd));
               chk("d_write_enable_MEM", {63'd0, d_write_enable_MEM}, {63'd0, e.we});
               chk("d_load_enable_MEM", {63'd0, d_load_enable_MEM}, {63'd0, e.le});
               if (!e.bubble) chk("S2_MEM", 64'(S2_MEM), 64'(e.s2));
               chk("pc_cmd_EX", {63'd0, pcc}, {63'd0, e.pc_cmd});
               chk("flush_EX", {63'd0, fl}, {63'd0, e.pc_cmd});
               chk("pc_in_EX", 64'(pin), 64'(e.pc_in));
            end
            st = 0;
         end
      end
   end

   initial begin
      instr_t t;
      drive(nop());
      reset_n = 1'b0;
      repeat (3) @(posedge clk);
      #2 reset_n = 1'b1;
      @(negedge clk);
      chk("reset_ALU_out_MEM", 64'(ALU_out_MEM), 64'd0);
      chk("reset_Rd_MEM", 64'(Rd_MEM), 64'd0);
      chk("reset_enables", {62'd0, d_write_enable_MEM, d_load_enable_MEM}, 64'd0);
      chk("reset_S2_MEM", 64'(S2_MEM), 64'd0);
      chk("reset_stall_flush_pccmd", {61'd0, stall_EX, flush_EX, pc_cmd_EX}, 64'd0);
      @(posedge clk);
      #2;
      sb_en = 1'b1;

      // MEM has priority over WB, then WB when MEM targets R0
      t = nop(); t.valid = 1; t.op = 4'd0; t.rd = 5'd1; t.rs1 = 5'd2; t.s1 = 32'h77;
      t.mem_rd = 5'd2; t.mem_out = 32'd5; t.wb_rd = 5'd2; t.wb_data = 32'd9;
      issue(t);
      t.mem_rd = 5'd0;
      issue(t);

      // Load-use: LW R3 then ADD R4,R3,R3 with the load value arriving via WB
      t = nop(); t.valid = 1; t.le = 1; t.rd = 5'd3; t.s1 = 32'h100; t.iv = 1; t.iv_v = 32'd4;
      issue(t);
      t = nop(); t.valid = 1; t.rd = 5'd4; t.rs1 = 5'd3; t.rs2 = 5'd3;
      t.wb_rd = 5'd3; t.wb_data = 32'd11;
      issue(t);

      // MDU: MUL 7*6, DIVU/REMU 100/7, divide by zero
      t = nop(); t.valid = 1; t.rd = 5'd6; t.op = 4'd9; t.s1 = 32'd7; t.s2 = 32'd6;
      issue(t);
      t.op = 4'd10; t.s1 = 32'd100; t.s2 = 32'd7;
      issue(t);
      t.op = 4'd11;
      issue(t);
      t.op = 4'd10; t.s1 = 32'd5; t.s2 = 32'd0;
      issue(t);
      t.op = 4'd11;
      issue(t);

      // Branch on zero SEQ result, then not taken on non-zero
      t = nop(); t.valid = 1; t.br = 1; t.op = 4'd8; t.iv = 1; t.iv_v = 32'h10;
      t.pc = 32'h40; t.s1 = 32'd3;
      issue(t);
      t.s1 = 32'h10;
      issue(t);

      for (int i = 0; i < 300; i++) issue(rand_instr());

      sb_en = 1'b0;
      chk("scoreboard_drained", 64'(q.size()), 64'd0);

      // Reset in the middle of a MUL aborts it
      t = nop(); t.valid = 1; t.op = 4'd9; t.s1 = 32'd7; t.s2 = 32'd6;
      drive(t);
      repeat (10) @(posedge clk);
      #1 chk("mul_busy_stall", {63'd0, stall_EX}, 64'd1);
      #1 reset_n = 1'b0;
      drive(nop());
      @(posedge clk);
      #2 reset_n = 1'b1;
      @(negedge clk);
      chk("abort_stall", {63'd0, stall_EX}, 64'd0);
      chk("abort_ALU_out_MEM", 64'(ALU_out_MEM), 64'd0);
      chk("abort_Rd_en", {57'd0, Rd_MEM, d_write_enable_MEM, d_load_enable_MEM}, 64'd0);
      @(posedge clk);
      #2;
      m_load = 1'b0;
      m_rd   = '0;
      sb_en  = 1'b1;
      t = nop(); t.valid = 1; t.op = 4'd0; t.rd = 5'd5; t.s1 = 32'd1; t.s2 = 32'd2;
      issue(t);
      sb_en = 1'b0;
      chk("final_queue_empty", 64'(q.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
